// File: rtl/uart_top.sv
// uart_top: message ROM feeding an 8N1 transmitter looped back into a receiver.
// Define UART_TOP_REPEAT_EN to resend the message continuously.
module uart_top #(
  parameter int clocks_per_bit = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       ser_tx,
  output logic [7:0] leds
);

  localparam int CW = $clog2(clocks_per_bit) + 1;
  localparam logic [CW-1:0] LAST = CW'(clocks_per_bit - 1);
  localparam logic [CW-1:0] FULL = CW'(clocks_per_bit);
  localparam logic [CW-1:0] HALF = CW'(clocks_per_bit / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [3:0] MSG_LEN = 4'd13;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_e;

  function automatic logic [7:0] msg_byte(input logic [3:0] i);
    case (i)
      4'd0:    msg_byte = 8'h48;
      4'd1:    msg_byte = 8'h65;
      4'd2:    msg_byte = 8'h6C;
      4'd3:    msg_byte = 8'h6C;
      4'd4:    msg_byte = 8'h6F;
      4'd5:    msg_byte = 8'h20;
      4'd6:    msg_byte = 8'h57;
      4'd7:    msg_byte = 8'h6F;
      4'd8:    msg_byte = 8'h72;
      4'd9:    msg_byte = 8'h6C;
      4'd10:   msg_byte = 8'h64;
      4'd11:   msg_byte = 8'h21;
      4'd12:   msg_byte = 8'h0A;
      default: msg_byte = 8'h00;
    endcase
  endfunction

  logic       out_valid;
  logic [7:0] out_data;

  logic [3:0]    idx_q, idx_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [7:0]    leds_q, leds_d;
  logic          tx_ready;
  logic          load;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      leds_q      <= '0;
    end else begin
      idx_q       <= idx_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      leds_q      <= leds_d;
    end
  end

  // Last stop cycle also accepts a load so frames run back to back.
  always_comb begin
    ser_tx   = 1'b1;
    tx_ready = 1'b0;
    case (tx_state_q)
      TX_IDLE:  tx_ready = 1'b1;
      TX_START: ser_tx = 1'b0;
      TX_DATA:  ser_tx = tx_shift_q[0];
      TX_STOP:  tx_ready = (tx_cnt_q == LAST);
      default:  ser_tx = 1'b1;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign leds      = leds_q;

  always_comb begin
`ifdef UART_TOP_REPEAT_EN
    load  = tx_ready;
    idx_d = idx_q;
    if (load) idx_d = (idx_q == MSG_LEN - 4'd1) ? 4'd0 : idx_q + 4'd1;
`else
    load  = tx_ready && (idx_q != MSG_LEN);
    idx_d = load ? idx_q + 4'd1 : idx_q;
`endif
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (load) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = msg_byte(idx_q);
        end
      end
      TX_START: begin
        if (tx_cnt_q == LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          if (load) begin
            tx_state_d = TX_START;
            tx_shift_d = msg_byte(idx_q);
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Down-counter samples when it reaches one: mid start bit, then every bit time.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    leds_d      = leds_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (!ser_tx) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF;
        end
      end
      RX_START: begin
        if (rx_cnt_q == ONE) begin
          if (ser_tx) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = FULL;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == ONE) begin
          rx_shift_d = {ser_tx, rx_shift_q[7:1]};
          rx_cnt_d   = FULL;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == ONE) begin
          if (ser_tx) begin
            out_valid_d = 1'b1;
            out_data_d  = rx_shift_q;
            leds_d      = rx_shift_q;
            rx_state_d  = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      RX_WAIT: begin
        if (ser_tx) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: scoreboard bench for uart_top at clocks_per_bit 3, 4 and 7.
// Works with or without UART_TOP_REPEAT_EN defined.
module tb_uart_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, rst47;
  logic tx3, tx4, tx7;
  logic [7:0] led3, led4, led7;

  uart_top #(.clocks_per_bit(3)) u3 (
    .clk(clk), .rst(rst3), .ser_tx(tx3), .leds(led3));
  uart_top #(.clocks_per_bit(4)) u4 (
    .clk(clk), .rst(rst47), .ser_tx(tx4), .leds(led4));
  uart_top #(.clocks_per_bit(7)) u7 (
    .clk(clk), .rst(rst47), .ser_tx(tx7), .leds(led7));

`ifdef UART_TOP_REPEAT_EN
  localparam int REP = 8;
`else
  localparam int REP = 1;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                           8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  function automatic int cpb_of(input int k);
    return (k == 0) ? 3 : (k == 1) ? 4 : 7;
  endfunction

  function automatic void push_msg(input int k);
    for (int r = 0; r < REP; r++)
      for (int i = 0; i < 13; i++)
        case (k)
          0: q0.push_back(msg[i]);
          1: q1.push_back(msg[i]);
          default: q2.push_back(msg[i]);
        endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  logic       ov [3];
  logic [7:0] od [3];
  logic [7:0] ld [3];
  assign ov[0] = u3.out_valid;
  assign ov[1] = u4.out_valid;
  assign ov[2] = u7.out_valid;
  assign od[0] = u3.out_data;
  assign od[1] = u4.out_data;
  assign od[2] = u7.out_data;
  assign ld[0] = led3;
  assign ld[1] = led4;
  assign ld[2] = led7;

  bit rs_e [3];
  always @(posedge clk) begin
    cyc++;
    rs_e[0] = rst3;
    rs_e[1] = rst47;
    rs_e[2] = rst47;
  end

  int  last_cyc [3];
  bit  have_prev [3];
  bit  chk_low [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rs_e[k]) begin
        have_prev[k] = 1'b0;
        chk_low[k]   = 1'b0;
      end else begin
        if (chk_low[k]) begin
          chk($sformatf("pulse_width_u%0d", cpb_of(k)), int'(ov[k]), 0);
          chk_low[k] = 1'b0;
        end
        if (ov[k]) begin
          if (qsize(k) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte_u%0d actual=0x%0h required=none",
                     cpb_of(k), od[k]);
          end else begin
            logic [7:0] e;
            e = qpop(k);
            chk($sformatf("out_data_u%0d", cpb_of(k)), int'(od[k]), int'(e));
            chk($sformatf("leds_u%0d", cpb_of(k)), int'(ld[k]), int'(e));
          end
          if (have_prev[k])
            chk($sformatf("spacing_u%0d", cpb_of(k)),
                cyc - last_cyc[k], 10 * cpb_of(k));
          last_cyc[k]  = cyc;
          have_prev[k] = 1'b1;
          chk_low[k]   = 1'b1;
        end
      end
    end
  end

  logic [9:0] frame;

  initial begin
    rst3  = 1'b1;
    rst47 = 1'b1;
    frame = {1'b1, 8'h48, 1'b0};

    repeat (15) begin
      @(negedge clk);
      chk("rst_ser_tx", int'(tx3), 1);
      chk("rst_leds", int'(led3), 0);
      chk("rst_out_valid", int'(u3.out_valid), 0);
    end
    chk("rst_out_data", int'(u3.out_data), 0);

    rst3  = 1'b0;
    rst47 = 1'b0;
    push_msg(0);
    push_msg(1);
    push_msg(2);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk($sformatf("frame0_bit%0d", i / 3), int'(tx3), int'(frame[i / 3]));
    end

    repeat (1000) @(negedge clk);
`ifndef UART_TOP_REPEAT_EN
    for (int k = 0; k < 3; k++)
      chk($sformatf("msg_done_u%0d", cpb_of(k)), qsize(k), 0);
    chk("final_leds_u3", int'(led3), 8'h0A);
    chk("final_leds_u4", int'(led4), 8'h0A);
    chk("final_leds_u7", int'(led7), 8'h0A);
    chk("idle_ser_tx_u7", int'(tx7), 1);
`endif

    rst3 = 1'b1;
    @(negedge clk);
    q0.delete();
    @(negedge clk);
    chk("rst2_leds", int'(led3), 0);
    rst3 = 1'b0;
    push_msg(0);

    repeat (70) @(negedge clk);
    chk("two_bytes_seen", qsize(0), REP * 13 - 2);
    rst3 = 1'b1;
    @(negedge clk);
    q0.delete();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_ser_tx", int'(tx3), 1);
      chk("midrst_out_valid", int'(u3.out_valid), 0);
      chk("midrst_index", int'(u3.idx_q), 0);
    end
    rst3 = 1'b0;
    push_msg(0);

    repeat (1000) @(negedge clk);
`ifndef UART_TOP_REPEAT_EN
    chk("restart_done", qsize(0), 0);
    chk("restart_leds", int'(led3), 8'h0A);
    chk("restart_idle", int'(tx3), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
